// File: rtl/if_layer_mem_sched.sv
// ----------------------------------------------------------------------------
// if_layer_mem_sched
//   Weight-memory access scheduler for an IF layer. Owns the layer's single
//   weight-memory port and multiplexes two users onto it:
//     * bulk loads: a valid/ready weight stream is written into every
//       neuron's memory in address order {neuron, index};
//     * single host reads/writes, accepted only while idle.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   start, abort             begin / cancel a bulk load
//   busy, done               scheduler active / one-cycle load-complete pulse
//   wt_data/valid/ready      weight stream (valid/ready handshake)
//   host_addr/din/wen/ren    host request ({neuron[27:8], index[7:0]})
//   host_rdy, host_ack       request accepted this cycle / write issued or
//                            read data valid
//   host_dout                last read data, held until the next read ack
//   mem_addr/din/wen/dout    layer weight-memory port
// ----------------------------------------------------------------------------
module if_layer_mem_sched #(
  parameter int WEIGHT_SIZE  = 32,
  parameter int NUM_INPUTS   = 4,
  parameter int NUM_NEURONS  = 1,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  input  logic [WEIGHT_SIZE-1:0] wt_data,
  input  logic                   wt_valid,
  output logic                   wt_ready,
  input  logic [27:0]            host_addr,
  input  logic [WEIGHT_SIZE-1:0] host_din,
  input  logic                   host_wen,
  input  logic                   host_ren,
  output logic                   host_rdy,
  output logic                   host_ack,
  output logic [WEIGHT_SIZE-1:0] host_dout,
  output logic [27:0]            mem_addr,
  output logic [WEIGHT_SIZE-1:0] mem_din,
  output logic                   mem_wen,
  input  logic [WEIGHT_SIZE-1:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_HWR      = 3'd2,
    S_HRD_WAIT = 3'd3,
    S_HRD_ACK  = 3'd4
  } state_e;

  localparam logic [7:0]  K_LAST   = 8'(NUM_INPUTS - 1);
  localparam logic [19:0] N_LAST   = 20'(NUM_NEURONS - 1);
  localparam logic [15:0] LAT_LAST = 16'(READ_LATENCY - 1);

  state_e                 state_q,     state_d;
  logic [19:0]            n_q,         n_d;
  logic [7:0]             k_q,         k_d;
  logic                   last_q,      last_d;
  logic [15:0]            lat_q,       lat_d;
  logic [27:0]            mem_addr_q,  mem_addr_d;
  logic [WEIGHT_SIZE-1:0] mem_din_q,   mem_din_d;
  logic                   mem_wen_q,   mem_wen_d;
  logic                   host_ack_q,  host_ack_d;
  logic [WEIGHT_SIZE-1:0] host_dout_q, host_dout_d;
  logic                   done_q,      done_d;

  logic                   wt_ready_s;
  logic                   wt_hs_s;

  // Handshake qualifiers: last_q blocks further beats while the final write
  // (and done) is in flight; abort blocks the beat on the abort edge.
  assign wt_ready_s = (state_q == S_LOAD) && !abort && !last_q;
  assign wt_hs_s    = wt_valid && wt_ready_s;

  assign wt_ready  = wt_ready_s;
  assign busy      = (state_q != S_IDLE);
  assign host_rdy  = (state_q == S_IDLE) && !start;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_wen   = mem_wen_q;
  assign host_ack  = host_ack_q;
  assign host_dout = host_dout_q;
  assign done      = done_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    last_d      = last_q;
    lat_d       = lat_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_wen_d   = 1'b0;
    host_ack_d  = 1'b0;
    host_dout_d = host_dout_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start has priority over host requests; a write beats a read.
        if (start) begin
          state_d = S_LOAD;
          n_d     = 20'd0;
          k_d     = 8'd0;
          last_d  = 1'b0;
        end else if (host_wen) begin
          // Outputs are registered, so the write is launched here to appear
          // during the single HWR cycle.
          state_d    = S_HWR;
          mem_addr_d = host_addr;
          mem_din_d  = host_din;
          mem_wen_d  = 1'b1;
          host_ack_d = 1'b1;
        end else if (host_ren) begin
          state_d    = S_HRD_WAIT;
          mem_addr_d = host_addr;
          lat_d      = 16'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        if (last_q || abort) begin
          // Either the final write/done cycle is on the port now, or the
          // load is being cancelled; no beat is taken in either case.
          state_d = S_IDLE;
          last_d  = 1'b0;
        end else if (wt_hs_s) begin
          mem_addr_d = {n_q, k_q};
          mem_din_d  = wt_data;
          mem_wen_d  = 1'b1;
          if (k_q == K_LAST) begin
            k_d = 8'd0;
            n_d = n_q + 20'd1;
            if (n_q == N_LAST) begin
              last_d = 1'b1;
              done_d = 1'b1;
            end else begin
              last_d = 1'b0;
            end
          end else begin
            k_d = k_q + 8'd1;
          end
        end else begin
          state_d = S_LOAD;
        end
      end

      S_HWR: begin
        state_d = S_IDLE;
      end

      S_HRD_WAIT: begin
        // Address has been stable for READ_LATENCY cycles at this edge.
        if (lat_q == LAT_LAST) begin
          host_dout_d = mem_dout;
          host_ack_d  = 1'b1;
          state_d     = S_HRD_ACK;
        end else begin
          lat_d = lat_q + 16'd1;
        end
      end

      S_HRD_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      n_q         <= 20'd0;
      k_q         <= 8'd0;
      last_q      <= 1'b0;
      lat_q       <= 16'd0;
      mem_addr_q  <= 28'd0;
      mem_din_q   <= {WEIGHT_SIZE{1'b0}};
      mem_wen_q   <= 1'b0;
      host_ack_q  <= 1'b0;
      host_dout_q <= {WEIGHT_SIZE{1'b0}};
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      last_q      <= last_d;
      lat_q       <= lat_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_wen_q   <= mem_wen_d;
      host_ack_q  <= host_ack_d;
      host_dout_q <= host_dout_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_if_layer_mem_sched.sv
// ----------------------------------------------------------------------------
// tb_if_layer_mem_sched
//   Directed self-checking bench for if_layer_mem_sched with two neurons of
//   four weights and a one-cycle (combinational-read) memory model.
// ----------------------------------------------------------------------------
module tb_if_layer_mem_sched;

  localparam int WS = 32;
  localparam int NI = 4;
  localparam int NN = 2;
  localparam int RL = 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic [WS-1:0] wt_data;
  logic          wt_valid;
  logic          wt_ready;
  logic [27:0]   host_addr;
  logic [WS-1:0] host_din;
  logic          host_wen;
  logic          host_ren;
  logic          host_rdy;
  logic          host_ack;
  logic [WS-1:0] host_dout;
  logic [27:0]   mem_addr;
  logic [WS-1:0] mem_din;
  logic          mem_wen;
  logic [WS-1:0] mem_dout;

  if_layer_mem_sched #(
    .WEIGHT_SIZE (WS),
    .NUM_INPUTS  (NI),
    .NUM_NEURONS (NN),
    .READ_LATENCY(RL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .wt_data  (wt_data),
    .wt_valid (wt_valid),
    .wt_ready (wt_ready),
    .host_addr(host_addr),
    .host_din (host_din),
    .host_wen (host_wen),
    .host_ren (host_ren),
    .host_rdy (host_rdy),
    .host_ack (host_ack),
    .host_dout(host_dout),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_wen  (mem_wen),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: write at the clock edge, read combinationally (latency 1).
  logic [WS-1:0] mem_arr [0:511];
  assign mem_dout = mem_arr[mem_addr[8:0]];
  always @(posedge clk) begin
    if (mem_wen) mem_arr[mem_addr[8:0]] <= mem_din;
  end

  // Port monitor: samples each cycle just after the rising edge.
  int          cyc_cnt;
  logic [27:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q  [$];
  int          done_cnt;
  int          done_cyc;
  int          ack_cnt;

  initial begin
    cyc_cnt  = 0;
    done_cnt = 0;
    done_cyc = -1;
    ack_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc_cnt++;
      if (mem_wen) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_din);
        wr_cyc_q.push_back(cyc_cnt);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
      end
      if (host_ack) ack_cnt++;
    end
  end

  int n_checks;
  int n_fails;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    ack_cnt  = 0;
  endtask

  // Called at a negedge in IDLE. Raises start for one cycle, then streams
  // beats 0x10+i until busy drops. abort_after >= 0 raises abort once that
  // many beats have been accepted. Returns the cycle following the start edge
  // and the first cycle seen idle again.
  task automatic run_load(input bit toggle, input int abort_after, input bit ren_during,
                          output int c_first, output int c_exit);
    int beats;
    int cyc;
    start    = 1'b1;
    wt_valid = 1'b0;
    #1;
    check_eq("rdy_low_on_start", 32'(host_rdy), 32'd0);
    @(negedge clk);
    start    = 1'b0;
    host_wen = 1'b0;
    c_first  = cyc_cnt;
    beats    = 0;
    cyc      = 0;
    while (busy && cyc < 200) begin
      abort    = (abort_after >= 0) && (beats == abort_after);
      wt_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      wt_data  = 32'h10 + 32'(beats);
      host_ren = ren_during;
      #1;
      if (wt_valid && wt_ready) beats++;
      @(negedge clk);
      cyc++;
    end
    check_eq("load_terminates", 32'(busy), 32'd0);
    abort    = 1'b0;
    wt_valid = 1'b0;
    host_ren = 1'b0;
    c_exit   = cyc_cnt;
  endtask

  // Checks a full 8-beat load: addresses {n,k}, data 0x10.., write spacing,
  // single done on the last write, busy low the cycle after done.
  task automatic check_full_load(input int step, input int c_first, input int c_exit);
    logic [31:0] exp_addr;
    check_eq("n_writes", 32'(wr_addr_q.size()), 32'(NN * NI));
    for (int i = 0; i < wr_addr_q.size() && i < NN * NI; i++) begin
      exp_addr = (32'(i / NI) << 8) | 32'(i % NI);
      check_eq("wr_addr", 32'(wr_addr_q[i]), exp_addr);
      check_eq("wr_data", wr_data_q[i], 32'h10 + 32'(i));
      check_eq("wr_cycle", 32'(wr_cyc_q[i]), 32'(c_first + 1 + step * i));
    end
    check_eq("done_count", 32'(done_cnt), 32'd1);
    if (wr_cyc_q.size() > 0) begin
      check_eq("done_with_last", 32'(done_cyc), 32'(wr_cyc_q[wr_cyc_q.size()-1]));
    end else begin
      check_eq("done_with_last", 32'(done_cyc), 32'hFFFF_FFFF);
    end
    check_eq("busy_falls", 32'(c_exit), 32'(done_cyc + 1));
  endtask

  int cf;
  int ce;
  int ack_before;

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    wt_data   = 32'd0;
    wt_valid  = 1'b0;
    host_addr = 28'd0;
    host_din  = 32'd0;
    host_wen  = 1'b0;
    host_ren  = 1'b0;
    for (int i = 0; i < 512; i++) mem_arr[i] = 32'd0;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_busy",      32'(busy),      32'd0);
    check_eq("rst_done",      32'(done),      32'd0);
    check_eq("rst_wt_ready",  32'(wt_ready),  32'd0);
    check_eq("rst_host_ack",  32'(host_ack),  32'd0);
    check_eq("rst_host_rdy",  32'(host_rdy),  32'd1);
    check_eq("rst_mem_wen",   32'(mem_wen),   32'd0);
    check_eq("rst_mem_addr",  32'(mem_addr),  32'd0);
    check_eq("rst_host_dout", host_dout,      32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back load
    clear_log();
    run_load(1'b0, -1, 1'b0, cf, ce);
    check_full_load(1, cf, ce);

    // Load with wt_valid toggling
    clear_log();
    run_load(1'b1, -1, 1'b0, cf, ce);
    check_full_load(2, cf, ce);

    // Host write then read of 0x101
    clear_log();
    host_addr = 28'h101;
    host_din  = 32'hDEAD_BEEF;
    host_wen  = 1'b1;
    #1;
    check_eq("hw_rdy", 32'(host_rdy), 32'd1);
    @(negedge clk);
    host_wen = 1'b0;
    check_eq("hw_mem_wen",  32'(mem_wen),  32'd1);
    check_eq("hw_ack",      32'(host_ack), 32'd1);
    check_eq("hw_mem_addr", 32'(mem_addr), 32'h101);
    check_eq("hw_mem_din",  mem_din,       32'hDEAD_BEEF);
    check_eq("hw_busy",     32'(busy),     32'd1);
    @(negedge clk);
    check_eq("hw_ack_pulse", 32'(host_ack), 32'd0);
    check_eq("hw_wen_pulse", 32'(mem_wen),  32'd0);
    check_eq("hw_rdy_back",  32'(host_rdy), 32'd1);
    check_eq("addr_holds",   32'(mem_addr), 32'h101);
    host_ren = 1'b1;
    @(negedge clk);
    host_ren = 1'b0;
    check_eq("hr_wait_ack",  32'(host_ack), 32'd0);
    check_eq("hr_mem_addr",  32'(mem_addr), 32'h101);
    check_eq("hr_mem_wen",   32'(mem_wen),  32'd0);
    check_eq("hr_rdy_low",   32'(host_rdy), 32'd0);
    @(negedge clk);
    check_eq("hr_ack",       32'(host_ack), 32'd1);
    check_eq("hr_dout",      host_dout,     32'hDEAD_BEEF);
    @(negedge clk);
    check_eq("hr_ack_pulse", 32'(host_ack), 32'd0);
    check_eq("hr_rdy_back",  32'(host_rdy), 32'd1);
    check_eq("hr_dout_hold", host_dout,     32'hDEAD_BEEF);
    check_eq("hrw_ack_cnt",  32'(ack_cnt),  32'd2);

    // Simultaneous write and read: write wins, read dropped
    clear_log();
    host_addr = 28'h002;
    host_din  = 32'h0000_00A5;
    host_wen  = 1'b1;
    host_ren  = 1'b1;
    @(negedge clk);
    host_wen = 1'b0;
    host_ren = 1'b0;
    check_eq("wr_wins_wen", 32'(mem_wen), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("rd_dropped_acks", 32'(ack_cnt), 32'd1);
    check_eq("wr_wins_mem",     mem_arr[2],   32'h0000_00A5);

    // start with host_wen: load wins; host_ren during load ignored
    clear_log();
    host_addr = 28'h003;
    host_din  = 32'h0000_0099;
    host_wen  = 1'b1;
    run_load(1'b0, -1, 1'b1, cf, ce);
    check_full_load(1, cf, ce);
    check_eq("no_host_ack", 32'(ack_cnt), 32'd0);
    check_eq("no_host_wr",  mem_arr[3],   32'h13);

    // Abort after beat 3, then restart
    clear_log();
    run_load(1'b0, 3, 1'b0, cf, ce);
    check_eq("abort_writes", 32'(wr_addr_q.size()), 32'd3);
    for (int i = 0; i < wr_addr_q.size() && i < 3; i++) begin
      check_eq("abort_addr", 32'(wr_addr_q[i]), 32'(i));
      check_eq("abort_data", wr_data_q[i], 32'h10 + 32'(i));
    end
    check_eq("abort_no_done", 32'(done_cnt), 32'd0);
    check_eq("abort_idle",    32'(ce),       32'(cf + 4));
    clear_log();
    run_load(1'b0, -1, 1'b0, cf, ce);
    check_full_load(1, cf, ce);

    // Reset during HRD_WAIT
    clear_log();
    host_addr = 28'h101;
    host_ren  = 1'b1;
    @(negedge clk);
    host_ren = 1'b0;
    check_eq("rw_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("rw_mem_addr",  32'(mem_addr), 32'd0);
    check_eq("rw_host_dout", host_dout,     32'd0);
    check_eq("rw_busy_low",  32'(busy),     32'd0);
    check_eq("rw_ack",       32'(host_ack), 32'd0);
    ack_before = ack_cnt;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rw_no_ack", 32'(ack_cnt), 32'(ack_before));

    // Reset during LOAD, then fresh load from 0x000
    start    = 1'b1;
    wt_valid = 1'b1;
    wt_data  = 32'h40;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wt_data = 32'h41;
    @(negedge clk);
    check_eq("rl_pre_wen", 32'(mem_wen), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("rl_mem_wen",  32'(mem_wen),  32'd0);
    check_eq("rl_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rl_mem_din",  mem_din,       32'd0);
    check_eq("rl_busy",     32'(busy),     32'd0);
    check_eq("rl_wt_ready", 32'(wt_ready), 32'd0);
    check_eq("rl_done",     32'(done),     32'd0);
    wt_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_log();
    run_load(1'b0, -1, 1'b0, cf, ce);
    check_full_load(1, cf, ce);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/if_layer_mem_sched.md
# if_layer_mem_sched

Weight-memory access scheduler for an IF layer. Sits between the host/register side and the layer's weight-memory port (`mem_addr`/`mem_din`/`mem_wen`/`mem_dout`). It sequences bulk weight loads from a valid/ready stream into every neuron's memory in address order. It also arbitrates single host reads and writes against those loads, so the layer port has exactly one driver.

## Interface
- `WEIGHT_SIZE`, 32, weight word width.
- `NUM_INPUTS`, 4, weights per neuron (1..256).
- `NUM_NEURONS`, 1, neurons in the layer (1..2^20).
- `READ_LATENCY`, 1, cycles from `mem_addr` stable to `mem_dout` valid (≥1).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a bulk load; sampled only in IDLE.
- `abort`  in  1  cancel a bulk load in progress.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse on completion of a full load.
- `wt_data`  in  WEIGHT_SIZE  streamed weight.
- `wt_valid`  in  1  `wt_data` valid.
- `wt_ready`  out  1  scheduler accepts a beat.
- `host_addr`  in  28  {neuron[27:8], index[7:0]}.
- `host_din`  in  WEIGHT_SIZE  host write data.
- `host_wen`  in  1  single-cycle host write request.
- `host_ren`  in  1  single-cycle host read request.
- `host_rdy`  out  1  host request will be accepted this cycle.
- `host_ack`  out  1  one-cycle pulse: write issued, or read data valid.
- `host_dout`  out  WEIGHT_SIZE  read data; held until the next read ack.
- `mem_addr`  out  28  to the layer.
- `mem_din`  out  WEIGHT_SIZE  to the layer.
- `mem_wen`  out  1  to the layer.
- `mem_dout`  in  WEIGHT_SIZE  from the layer.

## Operation
- States: IDLE, LOAD, HWR, HRD_WAIT, HRD_ACK.
- `mem_addr`, `mem_din`, `mem_wen`, `host_dout`, `host_ack` and `done` are registered.
- `host_rdy = (state==IDLE) && !start`, so `start` wins over a simultaneous host request.
- `wt_ready = (state==LOAD) && !abort && !last_accepted`.
- IDLE:
  - `start` goes to LOAD and clears the neuron counter `n` and the index counter `k`.
  - Otherwise, if `host_wen` is high, go to HWR.
  - Otherwise, if `host_ren` is high, go to HRD_WAIT.
  - When `host_wen` and `host_ren` are both high, the write wins and the read is dropped with no ack.
- Host requests arriving while `host_rdy=0` are ignored and never acked.
- HWR (one cycle):
  - Drives `mem_addr=host_addr`, `mem_din=host_din`, `mem_wen=1`, `host_ack=1`.
  - Returns to IDLE.
- HRD_WAIT:
  - Drives `mem_addr=host_addr` (latched), `mem_wen=0`.
  - Stays READ_LATENCY cycles, then captures `mem_dout` into `host_dout` and goes to HRD_ACK.
- HRD_ACK (one cycle): `host_ack=1`, then IDLE.
- LOAD:
  - Each handshake (`wt_valid && wt_ready` at an edge) produces a write in the next cycle: `mem_addr={n zero-extended to 20b, k[7:0]}`, `mem_din=wt_data`, `mem_wen=1`.
  - Then `k` increments. At `k==NUM_INPUTS-1`, `k` wraps to 0 and `n` increments.
  - Accepting the beat with `n==NUM_NEURONS-1, k==NUM_INPUTS-1` sets `last_accepted`.
  - The next cycle carries the final write plus `done=1`, and the state returns to IDLE.
  - Total beats per load: NUM_NEURONS·NUM_INPUTS.
- `wt_valid` low stalls LOAD indefinitely. `mem_wen=0` during stall cycles.
- `abort` in LOAD:
  - Returns to IDLE next edge with no `done`, and the beat on that edge is not accepted.
  - Writes already issued are not undone.
  - `abort` outside LOAD has no effect.
- `start` outside IDLE is ignored.
- Host `host_addr` is passed through unchecked; the layer decodes out-of-range selects.

## Timing
- Reset (`rst=0`):
  - State IDLE, `n=k=0`.
  - All outputs 0, except `host_rdy`, which follows its equation.
  - Asynchronous; mid-load or mid-read reset drops the operation with no ack or done.
- Host write accepted at edge T: `mem_wen` and `host_ack` high during cycle T+1.
- Host read accepted at edge T:
  - Address on `mem_addr` in cycles T+1 .. T+READ_LATENCY.
  - `host_ack` with valid `host_dout` in cycle T+1+READ_LATENCY.
  - `host_rdy` is high again in the cycle after the ack.
- Load with `wt_valid` held high:
  - Beat i is accepted at edge S+i and written in cycle S+i+1, where S is the first edge after the `start` edge.
  - `done` coincides with the last write.
  - `busy` is high from the cycle after `start` through the `done` cycle.
- `mem_addr` holds its last value when `mem_wen=0` and no read is in progress.

## Test plan
- NUM_NEURONS=2, NUM_INPUTS=4, `start` then 8 back-to-back beats 0x10..0x17 -> writes to addr 0x000..0x003, 0x100..0x103 on consecutive cycles with data 0x10..0x17; `done` pulses with the 0x103 write; `busy` falls next cycle.
- Same load with `wt_valid` toggling every other cycle -> identical address/data sequence, `mem_wen` only in cycles after handshakes, `done` exactly once.
- In IDLE, host write 0xDEADBEEF to 0x101, then host read 0x101 with a memory model of READ_LATENCY=1 -> `host_ack` 1 cycle after the write accept; read ack 2 cycles after accept with `host_dout=0xDEADBEEF`.
- `start` and `host_wen` in the same cycle -> load begins, host write not issued, no `host_ack`; `host_ren` during LOAD ignored.
- `abort` after beat 3 of 8 -> 3 writes only, beat on the abort edge not accepted, no `done`, IDLE next cycle; a following `start` restarts at addr 0x000.
- `rst` low during HRD_WAIT and during LOAD -> all outputs 0 immediately, no `host_ack`/`done`; after release a fresh load starts at 0x000.
